// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the input PIO: register offsets, edge-type encodings
// and the synchronizer priming depth.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam logic [1:0] PRIME_CYCLES = 2'd2;

  // Zero-extend a WIDTH-bit register image onto the 32-bit read bus.
  function automatic logic [31:0] zext32(input logic [31:0] val, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return val & mask;
  endfunction

endpackage

// File: rtl/soc_system_pio_in_sync.sv
// Two-flop synchronizer, previous-level register, priming counter and
// per-bit edge detector for the input PIO.
module soc_system_pio_in_sync
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [1:0]       r_prime;
  logic             r_armed;
  logic [WIDTH-1:0] w_raw_edge;

  // prime reaches 2 on the same edge that the first real sample lands in
  // sync2 while prev still holds its reset 0; arming one cycle later lets
  // prev catch up so a level held through reset is not seen as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_prime <= '0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_prime != PRIME_CYCLES) begin
        r_prime <= r_prime + 2'd1;
      end
      r_armed <= (r_prime == PRIME_CYCLES);
    end
  end

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign w_raw_edge = ~r_sync2 & r_prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign w_raw_edge = r_sync2 ^ r_prev;
    end else begin : g_rise
      assign w_raw_edge = r_sync2 & ~r_prev;
    end
  endgenerate

  assign o_level = r_sync2;
  assign o_edge  = w_raw_edge & {WIDTH{r_armed}};

endmodule

// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM input PIO: synchronized level readback, write-1-to-clear edge
// capture register and maskable level interrupt.
module soc_system_pio_in_edge
  import soc_system_pio_pkg::*;
#(
  parameter int          WIDTH          = 10,
  parameter int          EDGE_TYPE      = EDGE_RISE,
  parameter logic [31:0] IRQ_MASK_RESET = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdmux;
  logic             w_wr;
  logic             w_rd;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [31:0]      r_readdata;

  soc_system_pio_in_sync #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_in    (in_port),
    .o_level (w_level),
    .o_edge  (w_edge)
  );

  assign w_wr  = chipselect && !write_n;
  assign w_rd  = chipselect &&  write_n;
  assign w_clr = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  // Upper writedata bits are don't-care for a narrow PIO.
  assign w_unused_wdata = ^writedata;

  always_comb begin
    w_rdmux = 32'h0;
    case (address)
      ADDR_DATA:    w_rdmux = zext32(32'(w_level), WIDTH);
      ADDR_IRQMASK: w_rdmux = zext32(32'(r_irqmask), WIDTH);
      ADDR_EDGECAP: w_rdmux = zext32(32'(r_edgecap), WIDTH);
      default:      w_rdmux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask  <= IRQ_MASK_RESET[WIDTH-1:0];
      r_edgecap  <= '0;
      r_readdata <= 32'h0;
    end else begin
      if (w_wr && (address == ADDR_IRQMASK)) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
      // A new edge on a bit being cleared in the same cycle wins.
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      if (w_rd) begin
        r_readdata <= w_rdmux;
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// Directed bench: a rising-edge PIO (A) and an any-edge PIO (B) share one bus.
module tb_soc_system_pio_in_edge;

  localparam int W = 10;

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata_a, readdata_b;
  logic          irq_a, irq_b;

  int checks;
  int failures;

  soc_system_pio_in_edge #(.WIDTH(W), .EDGE_TYPE(0), .IRQ_MASK_RESET(32'h0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
    .in_port(in_port), .irq(irq_a)
  );

  soc_system_pio_in_edge #(.WIDTH(W), .EDGE_TYPE(2), .IRQ_MASK_RESET(32'h0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_b),
    .in_port(in_port), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] da, output logic [31:0] db);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    da = readdata_a;
    db = readdata_b;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] ra, rb;

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'h0; in_port = 10'h3FF;

    // Test 1: levels present through reset must not be captured
    wait_clks(3);
    chk("rst_irq_a", {31'h0, irq_a}, 32'h0);
    chk("rst_irq_b", {31'h0, irq_b}, 32'h0);
    chk("rst_rd_a", readdata_a, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    wait_clks(10);
    bus_read(2'd0, ra, rb);
    chk("t1_data_a", ra, 32'h3FF);
    chk("t1_data_b", rb, 32'h3FF);
    bus_read(2'd3, ra, rb);
    chk("t1_cap_a", ra, 32'h0);
    chk("t1_cap_b", rb, 32'h0);
    chk("t1_irq_a", {31'h0, irq_a}, 32'h0);

    // Drop all inputs: only the any-edge unit captures the falls
    @(negedge clk); in_port = 10'h000;
    wait_clks(5);
    bus_read(2'd3, ra, rb);
    chk("fall_cap_a", ra, 32'h0);
    chk("fall_cap_b", rb, 32'h3FF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, ra, rb);
    chk("clrall_a", ra, 32'h0);
    chk("clrall_b", rb, 32'h0);

    // Test 2: rising edge on bit0 with mask 0x001, exact latency
    bus_write(2'd2, 32'h0000_0001);
    bus_read(2'd2, ra, rb);
    chk("mask_rd_a", ra, 32'h1);
    @(negedge clk); in_port[0] = 1'b1;
    @(posedge clk);           // E0
    @(posedge clk); #1;       // E1
    chk("t2_irq_e1_a", {31'h0, irq_a}, 32'h0);
    @(posedge clk); #1;       // E2
    chk("t2_irq_e2_a", {31'h0, irq_a}, 32'h1);
    chk("t2_irq_e2_b", {31'h0, irq_b}, 32'h1);
    bus_read(2'd3, ra, rb);
    chk("t2_cap_a", ra, 32'h001);
    chk("t2_cap_b", rb, 32'h001);
    wait_clks(2);
    chk("t2_rd_hold", readdata_a, 32'h001);
    bus_read(2'd3, ra, rb);
    chk("t2_noclr_on_read", ra, 32'h001);

    // Test 3: write 0 leaves the capture, write 1 clears it
    bus_write(2'd3, 32'h0000_0000);
    chk("t3_w0_irq_a", {31'h0, irq_a}, 32'h1);
    bus_write(2'd3, 32'h0000_0001);
    chk("t3_w1_irq_a", {31'h0, irq_a}, 32'h0);
    chk("t3_w1_irq_b", {31'h0, irq_b}, 32'h0);
    bus_read(2'd3, ra, rb);
    chk("t3_cap_a", ra, 32'h0);

    // Test 4: clear bit3 on the very edge that captures bit3
    @(negedge clk); in_port[3] = 1'b1;
    @(posedge clk);           // E0
    @(posedge clk);           // E1
    bus_write(2'd3, 32'h0000_0008); // lands on E2
    bus_read(2'd3, ra, rb);
    chk("t4_setwins_a", ra, 32'h008);
    chk("t4_setwins_b", rb, 32'h008);
    bus_write(2'd3, 32'h0000_0008);
    bus_read(2'd3, ra, rb);
    chk("t4_clr_a", ra, 32'h0);

    // Test 5: pulse bit5 for 4 clocks with mask off, then unmask
    bus_write(2'd2, 32'h0000_0000);
    @(negedge clk); in_port[5] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); in_port[5] = 1'b0;
    wait_clks(5);
    chk("t5_irq_masked_a", {31'h0, irq_a}, 32'h0);
    chk("t5_irq_masked_b", {31'h0, irq_b}, 32'h0);
    bus_read(2'd3, ra, rb);
    chk("t5_cap_a", ra, 32'h020);
    chk("t5_cap_b", rb, 32'h020);
    bus_write(2'd2, 32'hFFFF_FC20);
    chk("t5_irq_unmask_a", {31'h0, irq_a}, 32'h1);
    chk("t5_irq_unmask_b", {31'h0, irq_b}, 32'h1);
    bus_read(2'd2, ra, rb);
    chk("t5_mask_upper_ignored", ra, 32'h020);

    // Falling edge on bit0 separates rising from any-edge capture
    @(negedge clk); in_port[0] = 1'b0;
    wait_clks(5);
    bus_read(2'd3, ra, rb);
    chk("fall0_a", ra, 32'h020);
    chk("fall0_b", rb, 32'h021);

    // Reserved and read-only addresses ignore writes
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd1, ra, rb);
    chk("rsvd_rd_a", ra, 32'h0);
    bus_read(2'd0, ra, rb);
    chk("data_after_wr_a", ra, 32'h008);
    chk("data_after_wr_b", rb, 32'h008);

    // Test 6: asynchronous reset mid-cycle with irq asserted
    chk("t6_pre_irq_a", {31'h0, irq_a}, 32'h1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_irq_a", {31'h0, irq_a}, 32'h0);
    chk("t6_async_irq_b", {31'h0, irq_b}, 32'h0);
    chk("t6_async_rd_a", readdata_a, 32'h0);
    chk("t6_async_rd_b", readdata_b, 32'h0);
    wait_clks(2);
    @(negedge clk); reset_n = 1'b1;
    wait_clks(10);
    bus_read(2'd2, ra, rb);
    chk("t6_mask_rst_a", ra, 32'h0);
    chk("t6_mask_rst_b", rb, 32'h0);
    bus_read(2'd3, ra, rb);
    chk("t6_cap_rst_a", ra, 32'h0);
    chk("t6_cap_rst_b", rb, 32'h0);
    bus_read(2'd1, ra, rb);
    chk("t6_rsvd_b", rb, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
